// File: rtl/multi_sym_ema_accumulators.sv
// multi_sym_ema_accumulators: per-symbol mid-price with fast/slow EMAs
//
// Two-stage pipeline: S1 holds the accepted sample (symbol, mid, saturated
// alphas, reject flag); S2 is the output register. Per-symbol EMA state is
// read combinationally from S1 and written on the S1->S2 edge, so a
// back-to-back sample for the same symbol always sees the fresh state.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready          sample handshake (in_sym, in_bid, in_ask)
//   cfg_alpha_fast/slow        Q1.15 alphas, captured with the sample
//   clr_valid/clr_sym          un-seed one symbol (and zero its count)
//   out_valid/out_ready        result handshake
//   out_sym, out_mid           symbol and mid (Q.FRAC_W)
//   out_ema_fast/slow          EMAs after the update
//   out_seeded, out_reject     seed / crossed-or-zero-book flags
//   out_count                  post-update per-symbol count
//
// Optional feature macro: ACC_UPD_CNT_EN enables the per-symbol 16-bit
// saturating update counters; without it out_count is tied to 0.
module multi_sym_ema_accumulators #(
    parameter int PRICE_W = 48,
    parameter int FRAC_W  = 16,
    parameter int N_SYM   = 8,
    parameter int SYM_W   = $clog2(N_SYM)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SYM_W-1:0]           in_sym,
    input  logic [PRICE_W-1:0]         in_bid,
    input  logic [PRICE_W-1:0]         in_ask,
    input  logic [15:0]                cfg_alpha_fast,
    input  logic [15:0]                cfg_alpha_slow,
    input  logic                       clr_valid,
    input  logic [SYM_W-1:0]           clr_sym,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SYM_W-1:0]           out_sym,
    output logic [PRICE_W+FRAC_W-1:0]  out_mid,
    output logic [PRICE_W+FRAC_W-1:0]  out_ema_fast,
    output logic [PRICE_W+FRAC_W-1:0]  out_ema_slow,
    output logic                       out_seeded,
    output logic                       out_reject,
    output logic [15:0]                out_count
);
    localparam int Q = PRICE_W + FRAC_W;

    logic             rdy_en;
    logic             s1_valid;
    logic [SYM_W-1:0] s1_sym;
    logic [Q-1:0]     s1_mid;
    logic [14:0]      s1_af;
    logic [14:0]      s1_as;
    logic             s1_rej;

    logic [Q-1:0]     ema_f [N_SYM];
    logic [Q-1:0]     ema_s [N_SYM];
    logic [N_SYM-1:0] seeded;

    logic             advance;
    logic             accept;
    logic             sym_ok;
    logic             clr_ok;
    logic             wr;
    logic [PRICE_W:0] sum;
    logic [Q-1:0]     in_mid;
    logic             in_rej;
    logic [Q-1:0]     cur_f;
    logic [Q-1:0]     cur_s;
    logic             seed;
    logic [Q-1:0]     nxt_f;
    logic [Q-1:0]     nxt_s;
    logic [15:0]      cnt_nxt;

    // (mid - ema) * alpha >>> 15 added back to ema. The product is taken
    // modulo 2^(Q+17) with the difference sign-extended, so the low bits
    // equal the signed product and the shifted slice floors correctly.
    function automatic logic [Q-1:0] ema_step(input logic [Q-1:0] ema,
                                              input logic [Q-1:0] mid,
                                              input logic [14:0]  a);
        logic [Q:0]    d;
        logic [Q+16:0] p;
        d = {1'b0, mid} - {1'b0, ema};
        p = {{16{d[Q]}}, d} * {{(Q + 2){1'b0}}, a};
        return ema + Q'(p >> 15);
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = rdy_en && (!s1_valid || advance);
    assign accept   = in_valid && in_ready;
    assign sym_ok   = 32'(in_sym) < N_SYM;
    assign clr_ok   = clr_valid && (32'(clr_sym) < N_SYM);
    assign wr       = advance && s1_valid;

    // (bid+ask) << FRAC_W >> 1 is the sum followed by FRAC_W-1 zero bits.
    assign sum    = {1'b0, in_bid} + {1'b0, in_ask};
    assign in_mid = {sum, {(FRAC_W - 1){1'b0}}};
    assign in_rej = (in_bid > in_ask) || (in_bid == '0) || (in_ask == '0);

    assign cur_f = ema_f[s1_sym];
    assign cur_s = ema_s[s1_sym];
    assign seed  = !seeded[s1_sym] && !s1_rej;

    always_comb begin
        nxt_f = s1_rej ? cur_f : seed ? s1_mid : ema_step(cur_f, s1_mid, s1_af);
        nxt_s = s1_rej ? cur_s : seed ? s1_mid : ema_step(cur_s, s1_mid, s1_as);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_sym   <= '0;
            s1_mid   <= '0;
            s1_af    <= '0;
            s1_as    <= '0;
            s1_rej   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (in_ready) begin
                // Out-of-range symbols are consumed but never enter S1.
                s1_valid <= accept && sym_ok;
                s1_sym   <= in_sym;
                s1_mid   <= in_mid;
                s1_af    <= cfg_alpha_fast[15] ? 15'h7FFF : cfg_alpha_fast[14:0];
                s1_as    <= cfg_alpha_slow[15] ? 15'h7FFF : cfg_alpha_slow[14:0];
                s1_rej   <= in_rej;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Clear is applied after the update so it wins on a same-edge collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_SYM; i++) begin
                ema_f[i] <= '0;
                ema_s[i] <= '0;
            end
            seeded <= '0;
        end else begin
            if (wr) begin
                ema_f[s1_sym] <= nxt_f;
                ema_s[s1_sym] <= nxt_s;
                if (!s1_rej) seeded[s1_sym] <= 1'b1;
            end
            if (clr_ok) seeded[clr_sym] <= 1'b0;
        end
    end

`ifdef ACC_UPD_CNT_EN
    logic [15:0] cnt [N_SYM];
    logic [15:0] cnt_cur;

    assign cnt_cur = cnt[s1_sym];
    assign cnt_nxt = (s1_rej || &cnt_cur) ? cnt_cur : cnt_cur + 16'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_SYM; i++) cnt[i] <= '0;
        end else begin
            if (wr) cnt[s1_sym] <= cnt_nxt;
            if (clr_ok) cnt[clr_sym] <= '0;
        end
    end
`else
    assign cnt_nxt = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_sym      <= '0;
            out_mid      <= '0;
            out_ema_fast <= '0;
            out_ema_slow <= '0;
            out_seeded   <= 1'b0;
            out_reject   <= 1'b0;
            out_count    <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sym      <= s1_sym;
                out_mid      <= s1_mid;
                out_ema_fast <= nxt_f;
                out_ema_slow <= nxt_s;
                out_seeded   <= seed;
                out_reject   <= s1_rej;
                out_count    <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_multi_sym_ema_accumulators.sv
// tb_multi_sym_ema_accumulators: directed checks of the multi-symbol EMA engine
module tb_multi_sym_ema_accumulators;
`ifdef ACC_UPD_CNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sym;
    logic [47:0] in_bid;
    logic [47:0] in_ask;
    logic [15:0] cfg_alpha_fast;
    logic [15:0] cfg_alpha_slow;
    logic        clr_valid;
    logic [2:0]  clr_sym;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_sym;
    logic [63:0] out_mid;
    logic [63:0] out_ema_fast;
    logic [63:0] out_ema_slow;
    logic        out_seeded;
    logic        out_reject;
    logic [15:0] out_count;

    multi_sym_ema_accumulators dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .in_bid(in_bid), .in_ask(in_ask),
        .cfg_alpha_fast(cfg_alpha_fast), .cfg_alpha_slow(cfg_alpha_slow),
        .clr_valid(clr_valid), .clr_sym(clr_sym),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_mid(out_mid), .out_ema_fast(out_ema_fast), .out_ema_slow(out_ema_slow),
        .out_seeded(out_seeded), .out_reject(out_reject), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0]  s_sym [4];
    logic [47:0] s_bid [4];
    logic [47:0] s_ask [4];
    logic [15:0] s_af  [4];
    logic [15:0] s_as  [4];

    logic [2:0]  r_sym  [8];
    logic [63:0] r_mid  [8];
    logic [63:0] r_f    [8];
    logic [63:0] r_s    [8];
    logic        r_seed [8];
    logic        r_rej  [8];
    logic [15:0] r_cnt  [8];
    int          r_cyc  [8];

    int   nr;
    int   acc_stall;
    int   clr_at = -1;
    logic rdy_stall;
    logic held;
    logic unstable;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int i, input int sym, input longint bid, input longint ask,
                       input int af = 1311, input int as = 2048);
        s_sym[i] = 3'(sym);
        s_bid[i] = 48'(bid);
        s_ask[i] = 48'(ask);
        s_af[i]  = 16'(af);
        s_as[i]  = 16'(as);
    endtask

    // Offers n queued samples, holding out_ready low for the first `stall`
    // cycles, and records every output transfer with its cycle number.
    task automatic run(input int n, input int stall);
        int idx = 0;
        logic acc;
        logic [63:0] hold = '0;
        nr = 0; acc_stall = 0; rdy_stall = 1'b1; held = 1'b0; unstable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (nr == n && idx == n) break;
            @(negedge clk);
            out_ready = (c >= stall);
            in_valid  = (idx < n);
            if (idx < n) begin
                in_sym = s_sym[idx]; in_bid = s_bid[idx]; in_ask = s_ask[idx];
                cfg_alpha_fast = s_af[idx]; cfg_alpha_slow = s_as[idx];
            end
            clr_valid = (c == clr_at);
            clr_sym   = 3'd4;
            #1;
            if (c == stall) acc_stall = idx;
            if (stall > 0 && c == stall - 1) rdy_stall = in_ready;
            if (out_valid && !out_ready) begin
                if (!held) begin held = 1'b1; hold = out_mid; end
                else if (out_mid !== hold) unstable = 1'b1;
            end
            if (out_valid && out_ready && nr < 8) begin
                r_sym[nr] = out_sym; r_mid[nr] = out_mid; r_f[nr] = out_ema_fast;
                r_s[nr] = out_ema_slow; r_seed[nr] = out_seeded; r_rej[nr] = out_reject;
                r_cnt[nr] = out_count; r_cyc[nr] = c;
                nr++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0; clr_valid = 1'b0; out_ready = 1'b1;
        check("n_out", 80'(nr), 80'(n));
    endtask

    task automatic exp_out(input string t, input int i, input int sym, input longint mid,
                           input longint f, input longint s, input int seed, input int rej,
                           input int cnt);
        check({t, ".sym"}, 80'(r_sym[i]), 80'(sym));
        check({t, ".mid"}, 80'(r_mid[i]), 80'(mid));
        check({t, ".fast"}, 80'(r_f[i]), 80'(f));
        check({t, ".slow"}, 80'(r_s[i]), 80'(s));
        check({t, ".seeded"}, 80'(r_seed[i]), 80'(seed));
        check({t, ".reject"}, 80'(r_rej[i]), 80'(rej));
        check({t, ".count"}, 80'(r_cnt[i]), 80'(cnt * CE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_sym = '0; in_bid = '0; in_ask = '0;
        cfg_alpha_fast = '0; cfg_alpha_slow = '0; clr_valid = 1'b0; clr_sym = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 80'(in_ready), 80'(0));
        check("rst.out_valid", 80'(out_valid), 80'(0));
        check("rst.out_mid", 80'(out_mid), 80'(0));
        check("rst.out_ema_slow", 80'(out_ema_slow), 80'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("rst.ready_after", 80'(in_ready), 80'(1));

        put(0, 3, 100, 102); run(1, 0);
        exp_out("seed", 0, 3, 'h650000, 'h650000, 'h650000, 1, 0, 1);
        put(0, 3, 110, 112); run(1, 0);
        exp_out("upd", 0, 3, 'h6F0000, 'h65666C, 'h65A000, 0, 0, 2);
        put(0, 3, 90, 90); run(1, 0);
        exp_out("floor", 0, 3, 'h5A0000, 'h64F1A8, 'h64E600, 0, 0, 3);

        put(0, 6, 10, 10); put(1, 6, 20, 20, 'hFFFF, 'h8000); run(2, 0);
        exp_out("sat0", 0, 6, 'hA0000, 'hA0000, 'hA0000, 1, 0, 1);
        exp_out("sat1", 1, 6, 'h140000, 'h13FFEC, 'h13FFEC, 0, 0, 2);

        put(0, 2, 200, 202); put(1, 2, 105, 104); put(2, 2, 0, 5); put(3, 2, 201, 203);
        run(4, 0);
        exp_out("rej0", 0, 2, 'hC90000, 'hC90000, 'hC90000, 1, 0, 1);
        exp_out("rej1", 1, 2, 'h688000, 'hC90000, 'hC90000, 0, 1, 1);
        exp_out("rej2", 2, 2, 'h28000, 'hC90000, 'hC90000, 0, 1, 1);
        exp_out("rej3", 3, 2, 'hCA0000, 'hC90A3E, 'hC91000, 0, 0, 2);

        put(0, 7, 5, 4); put(1, 7, 10, 10); run(2, 0);
        exp_out("unseed_rej", 0, 7, 'h48000, 0, 0, 0, 1, 0);
        exp_out("unseed_ok", 1, 7, 'hA0000, 'hA0000, 'hA0000, 1, 0, 1);

        put(0, 5, 20, 20); put(1, 5, 36, 36); put(2, 5, 36, 36); run(3, 0);
        exp_out("b2b0", 0, 5, 'h140000, 'h140000, 'h140000, 1, 0, 1);
        exp_out("b2b1", 1, 5, 'h240000, 'h14A3E0, 'h150000, 0, 0, 2);
        exp_out("b2b2", 2, 5, 'h240000, 'h154131, 'h15F000, 0, 0, 3);
        check("b2b.gap01", 80'(r_cyc[1] - r_cyc[0]), 80'(1));
        check("b2b.gap12", 80'(r_cyc[2] - r_cyc[1]), 80'(1));

        put(0, 1, 10, 10); put(1, 1, 10, 12); put(2, 1, 12, 12); run(3, 5);
        check("bp.accepted", 80'(acc_stall), 80'(2));
        check("bp.in_ready", 80'(rdy_stall), 80'(0));
        check("bp.held", 80'(held), 80'(1));
        check("bp.stable", 80'(unstable), 80'(0));
        exp_out("bp0", 0, 1, 'hA0000, 'hA0000, 'hA0000, 1, 0, 1);
        exp_out("bp1", 1, 1, 'hB0000, 'hA0A3E, 'hA1000, 0, 0, 2);
        exp_out("bp2", 2, 1, 'hC0000, 'hA1E51, 'hA2F00, 0, 0, 3);

        put(0, 4, 50, 50); run(1, 0);
        exp_out("clr_seed", 0, 4, 'h320000, 'h320000, 'h320000, 1, 0, 1);
        put(0, 4, 60, 60); clr_at = 1; run(1, 0); clr_at = -1;
        exp_out("clr_coll", 0, 4, 'h3C0000, 'h32666C, 'h32A000, 0, 0, 2);
        put(0, 4, 60, 60); run(1, 0);
        exp_out("clr_after", 0, 4, 'h3C0000, 'h3C0000, 'h3C0000, 1, 0, 1);

        @(negedge clk);
        in_valid = 1'b1; in_sym = 3'd0; in_bid = 48'd10; in_ask = 48'd10;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst.out_valid", 80'(out_valid), 80'(0));
        check("midrst.in_ready", 80'(in_ready), 80'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst.no_output", 80'(out_valid), 80'(0));
        put(0, 3, 100, 102); run(1, 0);
        exp_out("post_rst", 0, 3, 'h650000, 'h650000, 'h650000, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
